alu_driver: RTL and testbench
=============================

# alu_driver

Initiator-side sequencer for the 32-bit registered ALU (`alu`). It accepts operation requests over a valid/ready handshake and decodes the MIPS-style ALUOp/funct pair into the ALU's 3-bit control code. It drives operands and control into the ALU, waits out the ALU's one-cycle register latency, then captures R and zero into a held response. It sits between the decode/issue stage and the `alu` instance; `alu` shares clk and reset with it.

## Interface
- WIDTH, 32, operand/result width; must match `alu`.
- TAG_W, 4, width of the request tag returned unchanged with the response.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request (high only in IDLE).
- req_a, req_b  in  WIDTH  operands.
- req_aluop  in  2  00 = ADD (load/store), 01 = SUB (branch), 10 = R-type (use funct), 11 = illegal.
- req_funct  in  6  R-type funct field.
- req_tag  in  TAG_W  request identifier.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU A/B inputs.
- alu_ctrl  out  3  registered ALUControl.
- alu_r  in  WIDTH  ALU result R.
- alu_zero  in  1  ALU zero flag.
- resp_valid  out  1  response held.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  WIDTH  captured result.
- resp_zero  out  1  captured zero flag.
- resp_err  out  1  illegal operation.
- resp_tag  out  TAG_W  tag of the request being answered.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Decode (combinational, on the request fields):
  - aluop 00 → 000 (ADD); aluop 01 → 001 (SUB).
  - aluop 10: funct 100000 → 000, 100010 → 001, 100110 → 010, any other funct → illegal.
  - aluop 11 → illegal.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: req_ready = 1. On req_valid:
  - legal op: latch req_a, req_b and the decoded code into alu_a, alu_b, alu_ctrl; latch req_tag; go to EXEC.
  - illegal op: alu_* unchanged; set resp_err = 1, resp_data = 0, resp_zero = 0; latch tag; go to RESP.
- EXEC: alu_* held stable; the ALU registers R at the end of this cycle; go to CAPT.
- CAPT: alu_r and alu_zero are valid. Register them into resp_data and resp_zero; set resp_err = 0; go to RESP.
- RESP: resp_valid = 1. All resp_* are held stable until resp_valid && resp_ready, then go to IDLE.
- alu_a, alu_b and alu_ctrl keep their last values after issue. They change only on the next legal accept.
- Results wrap modulo 2^WIDTH. There is no overflow or carry reporting.
- resp_zero is taken from alu_zero, not recomputed locally.

## Timing
- Reset (synchronous, takes priority over everything, including mid-operation): state = IDLE; alu_a = 0, alu_b = 0, alu_ctrl = 000; resp_valid = 0, resp_data = 0, resp_zero = 0, resp_err = 0, resp_tag = 0; busy = 0; req_ready = 1 in the first cycle after reset. Any in-flight operation is dropped and produces no response.
- Legal op: accepted at edge T, alu_* valid from T. EXEC covers T to T+1, CAPT covers T+1 to T+2, resp_valid = 1 from T+2.
- Illegal op: accepted at edge T, resp_valid = 1 from T. The ALU is never touched.
- With resp_ready held high, a response is consumed in its first RESP cycle. req_ready rises the following cycle.
- Sustained throughput: one legal op per 4 cycles; one illegal op per 2 cycles.
- Requests and responses cannot be accepted in the same cycle, because req_ready = 0 outside IDLE.
- req_valid outside IDLE is ignored. The upstream stage must hold the request until it sees req_ready.

## Structure
- Package `alu_pkg` holds:
  - ALUControl codes: ALU_ADD = 000, ALU_SUB = 001, ALU_XOR = 010.
  - ALUOp encodings.
  - Funct constants: F_ADD, F_SUB, F_XOR.
  - The FSM state enum.
- One combinational sub-module, `alu_ctrl_decode`: inputs aluop and funct; outputs the 3-bit code and an illegal flag. It is shared with any other ALU initiator.
- `alu_driver` contains the FSM, the operand/tag registers and the response registers.

## Test plan
- ADD: aluop 00, a = 5, b = 7, tag = 3, resp_ready = 1 → alu_ctrl = 000 from the accept edge; resp_valid 2 cycles after accept with resp_data = 12, resp_zero = 0, resp_err = 0, resp_tag = 3.
- SUB equal (branch): aluop 01, a = b = 0x1234 → resp_data = 0, resp_zero = 1. Also a = 0, b = 1 → resp_data = 0xFFFFFFFF (wrap-around).
- R-type XOR: aluop 10, funct 100110, a = 0xF0F0F0F0, b = 0xFFFF0000 → resp_data = 0x0F0FF0F0. Also funct 101010 → resp_err = 1, resp_data = 0, resp_valid in the cycle after accept, alu_* unchanged.
- Backpressure: resp_ready = 0 for 5 cycles with req_valid held high → resp_* stable, req_ready = 0, no second accept. Then raise resp_ready → IDLE the next cycle, second request accepted one cycle later.
- Reset during EXEC and during RESP → next cycle: all outputs at their reset values, req_ready = 1, no stale response ever appears.
- Back-to-back: 4 legal ops with resp_ready = 1 → responses in order with matching tags, one every 4 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for ALU initiators: control codes, ALUOp/funct encodings
// and the driver FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;

    localparam logic [1:0] OP_LDST  = 2'b00;
    localparam logic [1:0] OP_BR    = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_XOR = 6'b100110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_CAPT = 2'b10,
        ST_RESP = 2'b11
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to ALUControl decoder with an illegal-op flag.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] code,
    output logic       illegal
);

    // Decode request fields; unsupported encodings raise illegal
    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        case (aluop)
            OP_LDST: code = ALU_ADD;
            OP_BR:   code = ALU_SUB;
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   code = ALU_ADD;
                    F_SUB:   code = ALU_SUB;
                    F_XOR:   code = ALU_XOR;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_driver.sv
// Initiator-side sequencer for the registered ALU: accepts a request, drives the
// ALU, waits out its register stage and holds the captured response.
module alu_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    logic [2:0] dec_code_s;
    logic       dec_illegal_s;
    state_t     state_r;

    alu_ctrl_decode u_decode (
        .aluop   (req_aluop),
        .funct   (req_funct),
        .code    (dec_code_s),
        .illegal (dec_illegal_s)
    );

    // Sequencer FSM with all outputs registered; req_ready/busy mirror IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 3'b000;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b0;
            resp_tag   <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        resp_tag  <= req_tag;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (dec_illegal_s) begin
                            // Illegal ops bypass the ALU and answer immediately
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            resp_zero  <= 1'b0;
                            resp_valid <= 1'b1;
                            state_r    <= ST_RESP;
                        end else begin
                            alu_a    <= req_a;
                            alu_b    <= req_b;
                            alu_ctrl <= dec_code_s;
                            state_r  <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: state_r <= ST_CAPT;
                ST_CAPT: begin
                    resp_data  <= alu_r;
                    resp_zero  <= alu_zero;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver with a behavioural registered ALU and a
// response scoreboard.
module tb_alu_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic [1:0]  req_aluop;
    logic [5:0]  req_funct;
    logic [3:0]  req_tag;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_r;
    logic        alu_zero;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_zero;
    logic        resp_err;
    logic [3:0]  resp_tag;
    logic        busy;

    alu_driver #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_aluop(req_aluop),
        .req_funct(req_funct), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_r(alu_r), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_zero(resp_zero),
        .resp_err(resp_err), .resp_tag(resp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural registered ALU: one cycle from operands to R
    logic [31:0] alu_r_m;
    always @(posedge clk) begin
        case (alu_ctrl)
            3'b000:  alu_r_m <= alu_a + alu_b;
            3'b001:  alu_r_m <= alu_a - alu_b;
            3'b010:  alu_r_m <= alu_a ^ alu_b;
            default: alu_r_m <= 32'd0;
        endcase
    end
    assign alu_r    = alu_r_m;
    assign alu_zero = (alu_r_m == 32'd0);

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [2:0]  ctrl;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        err;
        logic [3:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        got_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] la, lb;
    logic [2:0]  lc;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string ctx);
        chk({ctx, "_req_ready"},  32'(req_ready), 32'd1);
        chk({ctx, "_busy"},       32'(busy), 32'd0);
        chk({ctx, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({ctx, "_resp_data"},  resp_data, 32'd0);
        chk({ctx, "_resp_zero"},  32'(resp_zero), 32'd0);
        chk({ctx, "_resp_err"},   32'(resp_err), 32'd0);
        chk({ctx, "_resp_tag"},   32'(resp_tag), 32'd0);
        chk({ctx, "_alu_a"},      alu_a, 32'd0);
        chk({ctx, "_alu_b"},      alu_b, 32'd0);
        chk({ctx, "_alu_ctrl"},   32'(alu_ctrl), 32'd0);
    endtask

    // Response monitor: latency on each new response, field compare on handshake
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) begin
                chk("resp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0)
                    chk("resp_latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (resp_valid && resp_ready && sb.size() != 0) begin
                got_e = sb.pop_front();
                chk("resp_data", resp_data, got_e.data);
                chk("resp_zero", 32'(resp_zero), 32'(got_e.zero));
                chk("resp_err",  32'(resp_err), 32'(got_e.err));
                chk("resp_tag",  32'(resp_tag), 32'(got_e.tag));
            end
            prev_valid = resp_valid;
        end
    end

    task automatic drive(input vec_t v);
        req_aluop = v.aluop;
        req_funct = v.funct;
        req_a     = v.a;
        req_b     = v.b;
        req_tag   = v.tag;
    endtask

    task automatic push_exp(input vec_t v, input int acc);
        exp_t e;
        e.data = v.data; e.zero = v.zero; e.err = v.err; e.tag = v.tag;
        e.acc = acc; e.lat = v.err ? 0 : 2;
        sb.push_back(e);
    endtask

    // Check ALU-facing registers just after an accept edge
    task automatic check_issue(input vec_t v);
        if (!v.err) begin
            la = v.a; lb = v.b; lc = v.ctrl;
        end
        chk("alu_a",    alu_a, la);
        chk("alu_b",    alu_b, lb);
        chk("alu_ctrl", 32'(alu_ctrl), 32'(lc));
        chk("req_ready_after_accept", 32'(req_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic send(input vec_t v, output int acc);
        int n = 0;
        @(negedge clk);
        drive(v);
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        push_exp(v, acc);
        check_issue(v);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic wait_resp_valid();
        int n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid_seen", 32'(resp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];
    vec_t bp1, bp2;
    vec_t b2b[4];
    int   acc, accs[4];
    logic [31:0] held_data;

    initial begin
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        req_a = 32'd0; req_b = 32'd0; req_aluop = 2'b00; req_funct = 6'd0; req_tag = 4'd0;
        la = 32'd0; lb = 32'd0; lc = 3'b000;

        vecs[0] = '{2'b00, 6'd0,      32'd5,          32'd7,          4'd3,  3'b000, 32'd12,         1'b0, 1'b0};
        vecs[1] = '{2'b01, 6'd0,      32'h0000_1234,  32'h0000_1234,  4'd5,  3'b001, 32'd0,          1'b1, 1'b0};
        vecs[2] = '{2'b01, 6'd0,      32'd0,          32'd1,          4'd6,  3'b001, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[3] = '{2'b10, 6'b100110, 32'hF0F0_F0F0,  32'hFFFF_0000,  4'd7,  3'b010, 32'h0F0F_F0F0,  1'b0, 1'b0};
        vecs[4] = '{2'b10, 6'b101010, 32'h1111_1111,  32'h2222_2222,  4'd8,  3'b000, 32'd0,          1'b0, 1'b1};
        vecs[5] = '{2'b10, 6'b100000, 32'hFFFF_FFFF,  32'd1,          4'd9,  3'b000, 32'd0,          1'b1, 1'b0};
        vecs[6] = '{2'b10, 6'b100010, 32'd10,         32'd3,          4'd10, 3'b001, 32'd7,          1'b0, 1'b0};
        vecs[7] = '{2'b11, 6'b100000, 32'd99,         32'd98,         4'd11, 3'b000, 32'd0,          1'b0, 1'b1};
        vecs[8] = '{2'b00, 6'd0,      32'h8000_0000,  32'h8000_0000,  4'd12, 3'b000, 32'd0,          1'b1, 1'b0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs("por");

        for (int i = 0; i < 9; i++) send(vecs[i], acc);
        drain();

        // Backpressure: first response held while a second request waits
        bp1 = '{2'b00, 6'd0, 32'd100, 32'd23, 4'd1, 3'b000, 32'd123, 1'b0, 1'b0};
        bp2 = '{2'b01, 6'd0, 32'd50,  32'd8,  4'd2, 3'b001, 32'd42,  1'b0, 1'b0};
        resp_ready = 1'b0;
        send(bp1, acc);
        drive(bp2);
        req_valid = 1'b1;
        wait_resp_valid();
        held_data = resp_data;
        chk("bp_first_data", held_data, 32'd123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_data",  resp_data, held_data);
            chk("bp_resp_tag",   32'(resp_tag), 32'd1);
            chk("bp_req_ready",  32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        acc = cyc;
        push_exp(bp2, acc);
        check_issue(bp2);
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Reset while in EXEC: the operation must vanish
        send(vecs[0], acc);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk_reset_outputs("rst_exec");
        la = 32'd0; lb = 32'd0; lc = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_exec_no_resp", 32'(resp_valid), 32'd0);

        // Reset while a response is held
        resp_ready = 1'b0;
        send(vecs[6], acc);
        wait_resp_valid();
        reset = 1'b1;
        sb.delete();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rst_resp");
        la = 32'd0; lb = 32'd0; lc = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_resp_no_resp", 32'(resp_valid), 32'd0);

        // Back-to-back legal ops: one accept every 4 cycles, responses in order
        for (int i = 0; i < 4; i++) begin
            b2b[i] = '{2'b00, 6'd0, 32'(i * 1000), 32'(i + 1), 4'(i + 12), 3'b000,
                       32'(i * 1000 + i + 1), 1'b0, 1'b0};
        end
        for (int i = 0; i < 4; i++) send(b2b[i], accs[i]);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", accs[i] - accs[i-1], 32'd4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
